// File: rtl/md_pkg.sv
// Shared constants and FSM state encoding for the intra mode-decision fetch sequencer.
`default_nettype none

package md_pkg;

    localparam int MD_CNT_LAST = 40;
    localparam int MD_X_FIRST  = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RUN  = 2'd2,
        ST_FIN  = 2'd3
    } md_state_e;

endpackage

`default_nettype wire

// File: rtl/md_pp_flags.sv
// Ping-pong ownership flags for the two-bank pixel SRAM shared between loader and fetch.
`default_nettype none

module md_pp_flags (
    input  logic       clk,
    input  logic       rst,
    input  logic       set_i,
    input  logic       rel_i,
    input  logic       clr_i,
    output logic       wr_allow_o,
    output logic [1:0] full_o,
    output logic       wr_bank_o,
    output logic       rd_bank_o,
    output logic       ovf_err_o
);

    logic [1:0] full_q;
    logic       wr_bank_q;
    logic       rd_bank_q;
    logic       ovf_q;

    logic       w_accept;
    logic [1:0] w_set_mask;
    logic [1:0] w_rel_mask;

    assign w_accept   = set_i & ~full_q[wr_bank_q];
    assign w_set_mask = w_accept ? {wr_bank_q, ~wr_bank_q} : 2'b00;
    assign w_rel_mask = rel_i    ? {rd_bank_q, ~rd_bank_q} : 2'b00;

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q    <= 2'b00;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else if (clr_i) begin
            // Abort drops bank ownership but keeps the sticky overflow record.
            full_q    <= 2'b00;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
        end else begin
            full_q    <= (full_q | w_set_mask) & ~w_rel_mask;
            wr_bank_q <= wr_bank_q ^ w_accept;
            rd_bank_q <= rd_bank_q ^ rel_i;
            ovf_q     <= ovf_q | (set_i & ~w_accept);
        end
    end

    assign wr_allow_o = ~full_q[wr_bank_q];
    assign full_o     = full_q;
    assign wr_bank_o  = wr_bank_q;
    assign rd_bank_o  = rd_bank_q;
    assign ovf_err_o  = ovf_q;

endmodule

`default_nettype wire

// File: rtl/md_fetch_sched.sv
// Per-block fetch timeline sequencer: walks blk_num+1 blocks, consuming ping-pong banks.
`default_nettype none

module md_fetch_sched
    import md_pkg::*;
#(
    parameter int CNT_W    = 6,
    parameter int CNT_LAST = MD_CNT_LAST,
    parameter int BLK_W    = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BLK_W-1:0] blk_num,
    input  logic             kill,
    input  logic             load_done,
    output logic             wr_bank,
    output logic             wr_allow,
    output logic             fetch_enable,
    output logic [CNT_W-1:0] fetch_cnt,
    output logic             rd_bank,
    output logic             x_valid,
    output logic [BLK_W-1:0] blk_idx,
    output logic             blk_done,
    output logic             done,
    output logic             busy,
    output logic             ovf_err
);

    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(CNT_LAST);
    localparam logic [CNT_W-1:0] C_X_FIRST  = CNT_W'(MD_X_FIRST);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BLK_W-1:0] idx_q, idx_d;
    logic [BLK_W-1:0] last_q, last_d;
    logic             xv_q, xv_d;

    logic             w_blk_end;
    logic [1:0]       w_full;

    md_pp_flags u_flags (
        .clk        (clk),
        .rst        (rst),
        .set_i      (load_done),
        .rel_i      (w_blk_end),
        .clr_i      (kill),
        .wr_allow_o (wr_allow),
        .full_o     (w_full),
        .wr_bank_o  (wr_bank),
        .rd_bank_o  (rd_bank),
        .ovf_err_o  (ovf_err)
    );

    assign w_blk_end = (state_q == ST_RUN) && (cnt_q == C_CNT_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        last_d  = last_q;
        xv_d    = (state_q == ST_RUN) && (cnt_q >= C_X_FIRST);
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    last_d  = blk_num;
                    idx_d   = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = '0;
                if (w_full[rd_bank]) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!w_blk_end) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    cnt_d = '0;
                    if (idx_q == last_q) begin
                        state_d = ST_FIN;
                    end else begin
                        // The other bank decides between back-to-back and stalling.
                        idx_d   = idx_q + 1'b1;
                        state_d = w_full[~rd_bank] ? ST_RUN : ST_WAIT;
                    end
                end
            end
            ST_FIN: begin
                idx_d   = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || kill) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            last_q  <= '0;
            xv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            xv_q    <= xv_d;
        end
    end

    assign fetch_enable = (state_q == ST_RUN);
    assign fetch_cnt    = cnt_q;
    assign x_valid      = xv_q;
    assign blk_idx      = idx_q;
    assign blk_done     = w_blk_end;
    assign done         = (state_q == ST_FIN);
    assign busy         = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_md_fetch_sched.sv
// Directed plus randomized bench for md_fetch_sched against a job-level reference model.
`default_nettype none

module tb_md_fetch_sched;

    localparam int LAST = 40;
    localparam int XF   = 5;
    localparam int M_IDLE = 0, M_WAIT = 1, M_RUN = 2, M_FIN = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [5:0] blk_num = '0;
    logic       kill = 1'b0;
    logic       load_done = 1'b0;
    logic       wr_bank, wr_allow, fetch_enable, rd_bank, x_valid;
    logic [5:0] fetch_cnt, blk_idx;
    logic       blk_done, done, busy, ovf_err;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int m_mode, m_pos, m_blk, m_nblk, m_wb, m_rb;
    bit m_xv, m_ovf;
    bit m_full [2];

    md_fetch_sched dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .blk_num      (blk_num),
        .kill         (kill),
        .load_done    (load_done),
        .wr_bank      (wr_bank),
        .wr_allow     (wr_allow),
        .fetch_enable (fetch_enable),
        .fetch_cnt    (fetch_cnt),
        .rd_bank      (rd_bank),
        .x_valid      (x_valid),
        .blk_idx      (blk_idx),
        .blk_done     (blk_done),
        .done         (done),
        .busy         (busy),
        .ovf_err      (ovf_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock of the job/bank rules, using the values seen before the edge.
    task automatic model_step();
        bit ending, take;
        int old_wb, old_rb;
        bit other_full, cur_full;
        if (rst) begin
            m_mode = M_IDLE; m_pos = 0; m_blk = 0; m_nblk = 0; m_xv = 0;
            m_full[0] = 0; m_full[1] = 0; m_wb = 0; m_rb = 0; m_ovf = 0;
        end else if (kill) begin
            m_mode = M_IDLE; m_pos = 0; m_blk = 0; m_xv = 0;
            m_full[0] = 0; m_full[1] = 0; m_wb = 0; m_rb = 0;
        end else begin
            old_wb = m_wb; old_rb = m_rb;
            cur_full   = m_full[old_rb];
            other_full = m_full[1 - old_rb];
            ending = (m_mode == M_RUN) && (m_pos == LAST);
            m_xv   = (m_mode == M_RUN) && (m_pos >= XF) && (m_pos <= LAST);
            take   = load_done && !m_full[old_wb];
            if (load_done && !take) m_ovf = 1;
            if (take)   begin m_full[old_wb] = 1; m_wb = 1 - old_wb; end
            if (ending) begin m_full[old_rb] = 0; m_rb = 1 - old_rb; end
            case (m_mode)
                M_IDLE: if (start) begin m_nblk = int'(blk_num) + 1; m_blk = 0; m_mode = M_WAIT; end
                M_WAIT: begin m_pos = 0; if (cur_full) m_mode = M_RUN; end
                M_RUN: begin
                    if (!ending) m_pos = m_pos + 1;
                    else begin
                        m_pos = 0;
                        if (m_blk + 1 == m_nblk) m_mode = M_FIN;
                        else begin
                            m_blk = m_blk + 1;
                            m_mode = other_full ? M_RUN : M_WAIT;
                        end
                    end
                end
                default: begin m_mode = M_IDLE; m_blk = 0; end
            endcase
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("fetch_enable", fetch_enable, m_mode == M_RUN);
        chk("fetch_cnt", fetch_cnt, m_pos);
        chk("busy", busy, m_mode != M_IDLE);
        chk("done", done, m_mode == M_FIN);
        chk("blk_done", blk_done, (m_mode == M_RUN) && (m_pos == LAST));
        chk("blk_idx", blk_idx, m_blk);
        chk("x_valid", x_valid, m_xv);
        chk("wr_bank", wr_bank, m_wb);
        chk("rd_bank", rd_bank, m_rb);
        chk("wr_allow", wr_allow, !m_full[m_wb]);
        chk("ovf_err", ovf_err, m_ovf);
        start = 1'b0; load_done = 1'b0; kill = 1'b0;
    endtask

    // Runs until done; returns per-job activity counts.
    task automatic run_job(input string tag, output int runs, output int xvs, output int bds);
        bit seen = 0;
        runs = 0; xvs = 0; bds = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            tick();
            runs += fetch_enable; xvs += x_valid; bds += blk_done;
            seen = done;
        end
        chk({tag, "_done_seen"}, seen, 1);
    endtask

    task automatic wait_cnt20(input string tag);
        bit hit = 0;
        for (int i = 0; i < 200 && !hit; i++) begin
            tick();
            hit = fetch_enable && (fetch_cnt == 20);
        end
        chk({tag, "_cnt20_seen"}, hit, 1);
    endtask

    initial begin
        int runs, xvs, bds;
        bit bd_seen;
        tick(); tick();
        rst = 1'b0;
        tick();

        // 1: single block
        load_done = 1; tick();
        start = 1; blk_num = 0; tick();
        chk("t1_wait_en", fetch_enable, 0);
        run_job("t1", runs, xvs, bds);
        chk("t1_runs", runs, 41);
        chk("t1_xvalid", xvs, 36);
        chk("t1_blkdone", bds, 1);
        tick();

        // 2: two blocks back to back
        load_done = 1; tick(); load_done = 1; tick();
        start = 1; blk_num = 1; tick();
        run_job("t2", runs, xvs, bds);
        chk("t2_runs", runs, 82);
        chk("t2_blkdone", bds, 2);

        // 3: starvation after block 0
        load_done = 1; tick();
        start = 1; blk_num = 1; tick();
        bd_seen = 0;
        for (int i = 0; i < 100 && !bd_seen; i++) begin tick(); bd_seen = blk_done; end
        chk("t3_blk0_end", bd_seen, 1);
        for (int i = 0; i < 10; i++) begin tick(); chk("t3_stall_en", fetch_enable, 0); end
        load_done = 1; tick();
        chk("t3_not_yet", fetch_enable, 0);
        tick();
        chk("t3_resume_en", fetch_enable, 1);
        chk("t3_resume_cnt", fetch_cnt, 0);
        chk("t3_resume_idx", blk_idx, 1);
        run_job("t3", runs, xvs, bds);

        // 4: overflow
        load_done = 1; tick(); load_done = 1; tick();
        chk("t4_allow_full", wr_allow, 0);
        chk("t4_no_ovf", ovf_err, 0);
        load_done = 1; tick();
        chk("t4_ovf", ovf_err, 1);
        start = 1; blk_num = 1; tick();
        run_job("t4", runs, xvs, bds);
        chk("t4_runs", runs, 82);

        // 5: kill mid block
        load_done = 1; tick();
        start = 1; blk_num = 3; tick();
        wait_cnt20("t5");
        kill = 1; tick();
        chk("t5_busy", busy, 0);
        chk("t5_en", fetch_enable, 0);
        chk("t5_allow", wr_allow, 1);
        chk("t5_ovf_kept", ovf_err, 1);
        start = 1; blk_num = 0; tick();
        chk("t5_restart", busy, 1);
        kill = 1; tick();

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            load_done = ($urandom % 4) == 0;
            start     = ($urandom % 8) == 0;
            blk_num   = 6'($urandom % 4);
            kill      = ($urandom % 211) == 0;
            tick();
        end
        kill = 1; tick();

        // 6: reset mid block
        load_done = 1; tick();
        start = 1; blk_num = 0; tick();
        wait_cnt20("t6");
        rst = 1; tick();
        chk("t6_ovf", ovf_err, 0);
        chk("t6_en", fetch_enable, 0);
        chk("t6_cnt", fetch_cnt, 0);
        rst = 0; tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
